mxp_relu_nch: RTL and testbench



---
 rtl/cnn_pkg.sv | 19 +
 rtl/linebuf_sp.sv | 25 ++
 rtl/mxp_relu_nch.sv | 132 +++++++++++++
 tb/tb_mxp_relu_nch.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN definitions: default sample width and the signed compare/ReLU helpers
// used by pooling, conv layers and the comparator.
package cnn_pkg;

   localparam int unsigned CNN_DATA_BIT = 12;
   localparam int unsigned CNN_WORD_BIT = 32;

   typedef logic signed [CNN_WORD_BIT-1:0] cnn_word_t;

   // Callers sign-extend narrower samples into cnn_word_t before calling.
   function automatic logic cnn_sgt(input cnn_word_t a, input cnn_word_t b);
      return a > b;
   endfunction

   function automatic logic cnn_relu_clamp(input cnn_word_t x, input logic en);
      return en && (x < 0);
   endfunction

endpackage

// File: rtl/linebuf_sp.sv
// Register-array line buffer: synchronous write, combinational read.
module linebuf_sp #(
   parameter int unsigned DEPTH    = 12,
   parameter int unsigned WIDTH    = 36,
   parameter int unsigned ADDR_BIT = 4
) (
   input  logic                clk_i,
   input  logic                we_i,
   input  logic [ADDR_BIT-1:0] waddr_i,
   input  logic [WIDTH-1:0]    wdata_i,
   input  logic [ADDR_BIT-1:0] raddr_i,
   output logic [WIDTH-1:0]    rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mxp_relu_nch.sv
// 2x2 stride-2 signed max pooling with optional ReLU over NUM_CH parallel channels,
// raster-order input with gaps, synchronous frame clear and end-of-frame pulse.
module mxp_relu_nch
   import cnn_pkg::*;
#(
   parameter int unsigned DATA_BIT  = CNN_DATA_BIT,
   parameter int unsigned NUM_CH    = 3,
   parameter int unsigned IN_WIDTH  = 24,
   parameter int unsigned IN_HEIGHT = 24,
   parameter int unsigned COL_BIT   = 5,
   parameter int unsigned ROW_BIT   = 5,
   parameter int unsigned RELU_EN   = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       valid_in,
   input  logic [NUM_CH*DATA_BIT-1:0] data_in,
   output logic [NUM_CH*DATA_BIT-1:0] data_out,
   output logic                       valid_out,
   output logic                       frame_done
);

   localparam int unsigned VEC_BIT     = NUM_CH * DATA_BIT;
   localparam int unsigned LB_DEPTH    = IN_WIDTH / 2;
   localparam int unsigned LB_ADDR_BIT = (COL_BIT > 1) ? COL_BIT - 1 : 1;

   if ((IN_WIDTH % 2) != 0 || IN_WIDTH < 2 || (IN_HEIGHT % 2) != 0 || IN_HEIGHT < 2 ||
       (1 << COL_BIT) < IN_WIDTH || (1 << ROW_BIT) < IN_HEIGHT ||
       DATA_BIT > CNN_WORD_BIT || NUM_CH < 1) begin : gen_param_check
      $fatal(1, "mxp_relu_nch: illegal parameter combination");
   end

   logic [COL_BIT-1:0]     col_q, col_d;
   logic [ROW_BIT-1:0]     row_q, row_d;
   logic [VEC_BIT-1:0]     pair_q, pair_d;
   logic [VEC_BIT-1:0]     data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   done_q, done_d;

   logic                   col_last, row_last;
   logic                   lb_we;
   logic [LB_ADDR_BIT-1:0] lb_addr;
   logic [VEC_BIT-1:0]     lb_rdata;
   logic [VEC_BIT-1:0]     hmax;
   logic [VEC_BIT-1:0]     pool;

   assign col_last = (col_q == COL_BIT'(IN_WIDTH - 1));
   assign row_last = (row_q == ROW_BIT'(IN_HEIGHT - 1));
   assign lb_addr  = LB_ADDR_BIT'(col_q >> 1);

   linebuf_sp #(
      .DEPTH    (LB_DEPTH),
      .WIDTH    (VEC_BIT),
      .ADDR_BIT (LB_ADDR_BIT)
   ) u_linebuf (
      .clk_i   (clk),
      .we_i    (lb_we),
      .waddr_i (lb_addr),
      .wdata_i (hmax),
      .raddr_i (lb_addr),
      .rdata_o (lb_rdata)
   );

   for (genvar c = 0; c < NUM_CH; c++) begin : gen_ch
      logic signed [DATA_BIT-1:0] p_s, d_s, l_s, h_s, m_s;

      assign p_s = pair_q[c*DATA_BIT +: DATA_BIT];
      assign d_s = data_in[c*DATA_BIT +: DATA_BIT];
      assign l_s = lb_rdata[c*DATA_BIT +: DATA_BIT];
      assign h_s = cnn_sgt(cnn_word_t'(p_s), cnn_word_t'(d_s)) ? p_s : d_s;
      assign m_s = cnn_sgt(cnn_word_t'(l_s), cnn_word_t'(h_s)) ? l_s : h_s;

      assign hmax[c*DATA_BIT +: DATA_BIT] = h_s;
      assign pool[c*DATA_BIT +: DATA_BIT] =
         cnn_relu_clamp(cnn_word_t'(m_s), RELU_EN != 0) ? '0 : m_s;
   end

   always_comb begin
      col_d   = col_q;
      row_d   = row_q;
      pair_d  = pair_q;
      data_d  = data_q;
      valid_d = 1'b0;
      done_d  = 1'b0;
      lb_we   = 1'b0;
      if (clr) begin
         col_d = '0;
         row_d = '0;
      end else if (valid_in) begin
         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + ROW_BIT'(1);
         end else begin
            col_d = col_q + COL_BIT'(1);
         end
         // Even column opens a pair; odd column closes it on an even or odd row.
         if (!col_q[0]) begin
            pair_d = data_in;
         end else if (!row_q[0]) begin
            lb_we = 1'b1;
         end else begin
            data_d  = pool;
            valid_d = 1'b1;
            done_d  = col_last && row_last;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_q   <= '0;
         row_q   <= '0;
         pair_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         col_q   <= col_d;
         row_q   <= row_d;
         pair_q  <= pair_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   assign data_out   = data_q;
   assign valid_out  = valid_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_mxp_relu_nch.sv
// Bench for mxp_relu_nch: 4x4 frames into a ReLU and a pass-through instance, checked
// every cycle against a frame-image model plus hand-computed pooled values.
module tb_mxp_relu_nch;

   localparam int W  = 4;
   localparam int H  = 4;
   localparam int NC = 3;
   localparam int DB = 12;
   localparam int VB = NC * DB;

   logic          clk = 1'b0;
   logic          rst;
   logic          clr;
   logic          valid_in;
   logic [VB-1:0] data_in;
   logic [VB-1:0] data_n, data_r;
   logic          valid_n, valid_r, done_n, done_r;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   mxp_relu_nch #(
      .DATA_BIT (DB), .NUM_CH (NC), .IN_WIDTH (W), .IN_HEIGHT (H),
      .COL_BIT (2), .ROW_BIT (2), .RELU_EN (0)
   ) dut_n (
      .clk (clk), .rst (rst), .clr (clr), .valid_in (valid_in), .data_in (data_in),
      .data_out (data_n), .valid_out (valid_n), .frame_done (done_n)
   );

   mxp_relu_nch #(
      .DATA_BIT (DB), .NUM_CH (NC), .IN_WIDTH (W), .IN_HEIGHT (H),
      .COL_BIT (2), .ROW_BIT (2), .RELU_EN (1)
   ) dut_r (
      .clk (clk), .rst (rst), .clr (clr), .valid_in (valid_in), .data_in (data_in),
      .data_out (data_r), .valid_out (valid_r), .frame_done (done_r)
   );

   task automatic chk(input string name, input int got, input int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
   endtask

   function automatic int sval(input logic [VB-1:0] v, input int ch);
      logic signed [DB-1:0] t;
      t = v[ch*DB +: DB];
      return int'(t);
   endfunction

   function automatic logic [VB-1:0] pix(input int pat, input int idx);
      logic [VB-1:0] v;
      int x;
      v = '0;
      for (int c = 0; c < NC; c++) begin
         case (pat)
            0:       x = idx + 16 * c;
            1:       x = -idx - c;
            3:       x = 100 + idx + 16 * c;
            default: x = ((idx * 37 + c * 11) % 23) * 178 - 2048;
         endcase
         v[c*DB +: DB] = x[DB-1:0];
      end
      return v;
   endfunction

   // Model: remember the frame image, pool the 2x2 window when its last pixel lands.
   int img [H][W][NC];
   int m_n = 0;
   int m_v = 0;
   int m_done = 0;
   int m_dn [NC] = '{0, 0, 0};
   int m_dr [NC] = '{0, 0, 0};
   int mr, mc, mx;

   always @(negedge rst) begin
      m_n = 0; m_v = 0; m_done = 0;
      for (int c = 0; c < NC; c++) begin
         m_dn[c] = 0;
         m_dr[c] = 0;
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         m_v = 0;
         m_done = 0;
         if (clr) begin
            m_n = 0;
         end else if (valid_in) begin
            mr = m_n / W;
            mc = m_n % W;
            for (int c = 0; c < NC; c++) img[mr][mc][c] = sval(data_in, c);
            if (mr % 2 == 1 && mc % 2 == 1) begin
               for (int c = 0; c < NC; c++) begin
                  mx = img[mr][mc][c];
                  if (img[mr][mc-1][c] > mx) mx = img[mr][mc-1][c];
                  if (img[mr-1][mc][c] > mx) mx = img[mr-1][mc][c];
                  if (img[mr-1][mc-1][c] > mx) mx = img[mr-1][mc-1][c];
                  m_dn[c] = mx;
                  m_dr[c] = (mx < 0) ? 0 : mx;
               end
               m_v = 1;
               m_done = (m_n == W * H - 1) ? 1 : 0;
            end
            m_n = (m_n + 1) % (W * H);
         end
      end
   end

   logic [VB-1:0] qn [$];
   logic [VB-1:0] qr [$];
   int ndone = 0;

   always @(negedge clk) begin
      chk("valid_n", int'(valid_n), m_v);
      chk("valid_r", int'(valid_r), m_v);
      chk("done_n", int'(done_n), m_done);
      chk("done_r", int'(done_r), m_done);
      for (int c = 0; c < NC; c++) begin
         chk("data_n", sval(data_n, c), m_dn[c]);
         chk("data_r", sval(data_r, c), m_dr[c]);
      end
      if (valid_n) qn.push_back(data_n);
      if (valid_r) qr.push_back(data_r);
      if (done_n) ndone++;
   end

   task automatic drive(input logic [VB-1:0] v, input logic vl, input logic cl);
      @(posedge clk);
      #2;
      data_in  = v;
      valid_in = vl;
      clr      = cl;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(pix(2, i + 7), 1'b0, 1'b0);
   endtask

   task automatic send_pixels(input int pat, input int first, input int count, input int gap);
      for (int i = first; i < first + count; i++) begin
         drive(pix(pat, i), 1'b1, 1'b0);
         if (gap != 0) idle(2);
      end
   endtask

   task automatic clear_log();
      qn.delete();
      qr.delete();
      ndone = 0;
   endtask

   // Channel-0 values of four pass-through outputs starting at log entry 'first'.
   task automatic lit4(input string tag, input int first, input int e0, input int e1,
                       input int e2, input int e3);
      int e [4];
      e = '{e0, e1, e2, e3};
      for (int k = 0; k < 4; k++) begin
         if (qn.size() > first + k) chk(tag, sval(qn[first+k], 0), e[k]);
         else chk({tag, "_missing"}, qn.size(), first + k + 1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; clr = 1'b0; valid_in = 1'b0; data_in = '0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      idle(2);

      // Raster index as value: pooled map 5,7,13,15.
      clear_log();
      send_pixels(0, 0, 16, 0);
      idle(3);
      chk("t1_count", qn.size(), 4);
      lit4("t1_vals", 0, 5, 7, 13, 15);
      chk("t1_done", ndone, 1);
      if (qr.size() > 3) chk("t1_relu_ch2", sval(qr[3], 2), 47);

      // All-negative channels: ReLU gives zeros, raw max gives 0,-1,-2 first.
      clear_log();
      send_pixels(1, 0, 16, 0);
      idle(3);
      chk("t2_count", qr.size(), 4);
      for (int k = 0; k < qr.size(); k++) chk("t2_relu_zero", int'(qr[k] == '0), 1);
      if (qn.size() > 0) begin
         chk("t2_raw_ch0", sval(qn[0], 0), 0);
         chk("t2_raw_ch1", sval(qn[0], 1), -1);
         chk("t2_raw_ch2", sval(qn[0], 2), -2);
      end

      // Gaps between pixels must not change values or order.
      clear_log();
      send_pixels(0, 0, 16, 1);
      idle(3);
      chk("t3_count", qn.size(), 4);
      lit4("t3_vals", 0, 5, 7, 13, 15);

      // Two back-to-back frames.
      clear_log();
      send_pixels(1, 0, 16, 0);
      send_pixels(0, 0, 16, 0);
      idle(3);
      chk("t4_count", qn.size(), 8);
      chk("t4_done", ndone, 2);
      if (qn.size() > 0) chk("t4_first", sval(qn[0], 0), 0);
      lit4("t4_second", 4, 5, 7, 13, 15);

      // Clear after 6 pixels, with a pixel presented alongside clr.
      clear_log();
      send_pixels(3, 0, 6, 0);
      drive(pix(3, 9), 1'b1, 1'b1);
      send_pixels(0, 0, 16, 0);
      idle(3);
      chk("t5_count", qn.size(), 5);
      if (qn.size() > 0) chk("t5_pending", sval(qn[0], 0), 105);
      lit4("t5_fresh", 1, 5, 7, 13, 15);
      chk("t5_done", ndone, 1);

      // Asynchronous reset while an output pulse is showing.
      clear_log();
      send_pixels(3, 0, 6, 0);
      @(posedge clk);
      #2;
      valid_in = 1'b0;
      rst = 1'b0;
      #1;
      chk("t6_valid_n", int'(valid_n), 0);
      chk("t6_valid_r", int'(valid_r), 0);
      chk("t6_data_n", int'(data_n == '0), 1);
      chk("t6_data_r", int'(data_r == '0), 1);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      clear_log();
      send_pixels(0, 0, 16, 0);
      idle(3);
      chk("t6_count", qn.size(), 4);
      lit4("t6_vals", 0, 5, 7, 13, 15);

      // Mixed-sign wide-range frame with gaps, model-checked only.
      send_pixels(2, 0, 16, 1);
      idle(3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
